// File: rtl/handshake_transmitter.sv
// Four-phase req/ack transmitter: takes words from a valid/ready source, holds them on
// data_out and runs the full req/ack cycle; rejects all-ones words and bounds the ack wait.
module handshake_transmitter #(
    parameter int DATA_WIDTH     = 4,
    parameter int SETUP_CYCLES   = 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] send_data,
    input  logic                  send_valid,
    output logic                  send_ready,
    input  logic                  ack_in,
    output logic                  req_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  done_pulse,
    output logic                  reject_pulse,
    output logic                  timeout_pulse
);

    localparam int CNT_MAX = (SETUP_CYCLES > TIMEOUT_CYCLES) ? SETUP_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {IDLE, SETUP, REQ_HIGH, WAIT_ACK_LOW} state_t;

    state_t                state, state_next;
    logic                  ack_meta, ack_sync;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic                  timed_out, timed_out_next;
    logic                  req_next, done_next, reject_next, timeout_next;
    logic [DATA_WIDTH-1:0] data_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_meta <= 1'b0;
            ack_sync <= 1'b0;
        end else begin
            ack_meta <= ack_in;
            ack_sync <= ack_meta;
        end
    end

    // A stale-high ack (e.g. left over from before reset) keeps new transfers out.
    assign send_ready = (state == IDLE) && !ack_sync && reset;
    assign busy       = (state != IDLE);

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        timed_out_next = timed_out;
        req_next       = req_out;
        data_next      = data_out;
        done_next      = 1'b0;
        reject_next    = 1'b0;
        timeout_next   = 1'b0;
        case (state)
            IDLE: begin
                if (send_valid && send_ready) begin
                    if (&send_data) begin
                        reject_next = 1'b1;
                    end else begin
                        data_next      = send_data;
                        cnt_next       = '0;
                        timed_out_next = 1'b0;
                        state_next     = SETUP;
                    end
                end
            end
            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    req_next   = 1'b1;
                    cnt_next   = '0;
                    state_next = REQ_HIGH;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            REQ_HIGH: begin
                // Ack is tested first so it wins over a timeout expiring on the same edge.
                if (ack_sync) begin
                    req_next   = 1'b0;
                    state_next = WAIT_ACK_LOW;
                end else if (TO_EN && (cnt == TO_LAST)) begin
                    req_next       = 1'b0;
                    timeout_next   = 1'b1;
                    timed_out_next = 1'b1;
                    state_next     = WAIT_ACK_LOW;
                end else if (TO_EN) begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            WAIT_ACK_LOW: begin
                if (!ack_sync) begin
                    done_next  = !timed_out;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            timed_out     <= 1'b0;
            req_out       <= 1'b0;
            data_out      <= '0;
            done_pulse    <= 1'b0;
            reject_pulse  <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            timed_out     <= timed_out_next;
            req_out       <= req_next;
            data_out      <= data_next;
            done_pulse    <= done_next;
            reject_pulse  <= reject_next;
            timeout_pulse <= timeout_next;
        end
    end

endmodule

// File: tb/tb_handshake_transmitter.sv
// Directed bench for handshake_transmitter at default parameters (4-bit word, setup 1, timeout 16).
module tb_handshake_transmitter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] send_data;
    logic       send_valid;
    logic       send_ready;
    logic       ack_in;
    logic       req_out;
    logic [3:0] data_out;
    logic       busy;
    logic       done_pulse;
    logic       reject_pulse;
    logic       timeout_pulse;

    int total = 0;
    int bad   = 0;

    handshake_transmitter dut (
        .clk          (clk),
        .reset        (reset),
        .send_data    (send_data),
        .send_valid   (send_valid),
        .send_ready   (send_ready),
        .ack_in       (ack_in),
        .req_out      (req_out),
        .data_out     (data_out),
        .busy         (busy),
        .done_pulse   (done_pulse),
        .reject_pulse (reject_pulse),
        .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transfer with a receiver answering 3 cycles after each req edge.
    task automatic xfer(input logic [3:0] w);
        send_data  = w;
        send_valid = 1'b1;
        tick();
        chk("acc_data", data_out, w);
        chk("acc_busy", busy, 1);
        chk("acc_req", req_out, 0);
        chk("acc_done_clr", done_pulse, 0);
        send_valid = 1'b0;
        tick();
        chk("req_rise", req_out, 1);
        tick();
        tick();
        ack_in = 1'b1;
        tick();
        tick();
        chk("req_hold", req_out, 1);
        tick();
        chk("req_fall", req_out, 0);
        tick();
        tick();
        tick();
        ack_in = 1'b0;
        tick();
        tick();
        chk("wait_busy", busy, 1);
        chk("done_early", done_pulse, 0);
        tick();
        chk("done", done_pulse, 1);
        chk("ready_back", send_ready, 1);
        chk("busy_clr", busy, 0);
        chk("data_hold", data_out, w);
    endtask

    initial begin
        int hi;
        int to;
        int dn;
        reset      = 1'b0;
        send_valid = 1'b0;
        send_data  = 4'h0;
        ack_in     = 1'b0;
        #2;
        chk("rst_req", req_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", send_ready, 0);
        chk("rst_pulses", {done_pulse, reject_pulse, timeout_pulse}, 0);
        tick();
        tick();
        chk("rst_ready_held", send_ready, 0);
        reset = 1'b1;
        tick();
        chk("rel_ready", send_ready, 1);
        chk("rel_busy", busy, 0);

        // normal transfer
        xfer(4'h5);

        // all-ones rejected, next word accepted on the following cycle
        send_data  = 4'hF;
        send_valid = 1'b1;
        tick();
        chk("rej_pulse", reject_pulse, 1);
        chk("rej_req", req_out, 0);
        chk("rej_data", data_out, 4'h5);
        chk("rej_busy", busy, 0);
        send_data = 4'h3;
        tick();
        chk("rej_pulse_off", reject_pulse, 0);
        chk("after_rej_data", data_out, 4'h3);
        chk("after_rej_busy", busy, 1);
        send_valid = 1'b0;

        // no ack at all: req high 16 cycles, then timeout
        hi = 0;
        to = 0;
        dn = 0;
        for (int i = 0; i < 17; i++) begin
            tick();
            hi += int'(req_out);
            to += int'(timeout_pulse);
            dn += int'(done_pulse);
        end
        chk("to_req_cycles", hi, 16);
        chk("to_pulse_count", to, 1);
        chk("to_req_low", req_out, 0);
        chk("to_busy", busy, 1);
        tick();
        chk("to_idle", busy, 0);
        chk("to_pulse_off", timeout_pulse, 0);
        chk("to_no_done", done_pulse + dn, 0);
        chk("to_ready", send_ready, 1);

        // ack synchronised exactly on the expiry edge wins over the timeout
        send_data  = 4'h7;
        send_valid = 1'b1;
        tick();
        send_valid = 1'b0;
        repeat (14) tick();
        ack_in = 1'b1;
        tick();
        tick();
        chk("prio_req_hold", req_out, 1);
        tick();
        chk("prio_req_fall", req_out, 0);
        chk("prio_no_timeout", timeout_pulse, 0);
        ack_in = 1'b0;
        tick();
        tick();
        tick();
        chk("prio_done", done_pulse, 1);

        // late ack lands as the timeout fires: block holds until ack falls, no done
        send_data  = 4'h6;
        send_valid = 1'b1;
        tick();
        send_valid = 1'b0;
        repeat (15) tick();
        ack_in = 1'b1;
        tick();
        tick();
        chk("late_timeout", timeout_pulse, 1);
        chk("late_req_low", req_out, 0);
        dn = 0;
        hi = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            hi += int'(busy);
            dn += int'(done_pulse);
        end
        chk("late_busy_cycles", hi, 3);
        ack_in = 1'b0;
        tick();
        tick();
        chk("late_hold", busy, 1);
        tick();
        chk("late_idle", busy, 0);
        chk("late_no_done", done_pulse + dn, 0);
        chk("late_ready", send_ready, 1);

        // back-to-back stream
        xfer(4'h1);
        xfer(4'h2);
        xfer(4'h3);

        // reset while in REQ_HIGH, ack held high through release
        send_data  = 4'h4;
        send_valid = 1'b1;
        tick();
        send_valid = 1'b0;
        tick();
        chk("pre_rst_req", req_out, 1);
        ack_in = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_req", req_out, 0);
        chk("mid_rst_data", data_out, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", send_ready, 0);
        chk("mid_rst_pulses", {done_pulse, reject_pulse, timeout_pulse}, 0);
        #2;
        reset = 1'b1;
        tick();
        tick();
        chk("stale_ack_ready0", send_ready, 0);
        tick();
        chk("stale_ack_ready1", send_ready, 0);
        chk("stale_ack_pulses", {done_pulse, reject_pulse, timeout_pulse}, 0);
        ack_in = 1'b0;
        tick();
        chk("stale_ack_ready2", send_ready, 0);
        tick();
        chk("stale_ack_gone", send_ready, 1);

        xfer(4'h9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
